mt_state_buf: RTL

MT_STATE_BUF -- requirements
Module: mt_state_buf

---
 rtl/mt_pkg.sv | 35 +++
 rtl/mt_seed_step.sv | 24 ++
 rtl/mt_state_buf.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mt_pkg.sv
// Shared types and constants for the Mersenne Twister state buffer.
package mt_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StInit,
        StReady
    } state_e;

    // Seed used when the block seeds itself after reset.
    localparam logic [63:0] DEFAULT_SEED = 64'd5489;

    // Seeding recurrence constants for the 32-bit and 64-bit generator variants.
    localparam logic [63:0] MULT_32  = 64'd1812433253;
    localparam logic [63:0] MULT_64  = 64'd6364136223846793005;
    localparam int unsigned SHIFT_32 = 30;
    localparam int unsigned SHIFT_64 = 62;

    function automatic logic [63:0] mult_for(input int unsigned w);
        return (w == 64) ? MULT_64 : MULT_32;
    endfunction

    function automatic int unsigned shift_for(input int unsigned w);
        return (w == 64) ? SHIFT_64 : SHIFT_32;
    endfunction

    // (base + off) mod n, valid when base < n and off <= n.
    function automatic int unsigned wrap_add(input int unsigned base, input int unsigned off,
                                             input int unsigned n);
        int unsigned s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/mt_seed_step.sv
// One step of the seeding recurrence: next = MULT * (prev ^ (prev >> SHIFT)) + index.
module mt_seed_step
    import mt_pkg::*;
#(
    parameter int unsigned W  = 32,
    parameter int unsigned IW = 10
) (
    input  logic [W-1:0]  prev_word,
    input  logic [IW-1:0] index,
    output logic [W-1:0]  next_word
);

    localparam logic [W-1:0] Mult  = W'(mult_for(W));
    localparam int unsigned  Shift = shift_for(W);

    logic [W-1:0] mixed;

    // Product is truncated to W bits, giving the mod 2^W arithmetic for free.
    always_comb begin
        mixed     = prev_word ^ (prev_word >> Shift);
        next_word = (mixed * Mult) + W'(index);
    end

endmodule

// File: rtl/mt_state_buf.sv
// Mersenne Twister state array: seeding sequencer, twist taps and update port.
// Optional feature macro: MT_STATE_AUTOSEED_EN (self-seed with DEFAULT_SEED after reset).
module mt_state_buf
    import mt_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned N = 624,
    parameter int unsigned M = 397
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 seed_valid,
    input  logic [W-1:0]         seed,
    output logic                 seed_ready,
    output logic                 busy,
    output logic                 ready,
    output logic [$clog2(N)-1:0] idx,
    output logic [W-1:0]         tap_i,
    output logic [W-1:0]         tap_i1,
    output logic [W-1:0]         tap_im,
    input  logic                 upd_valid,
    input  logic [W-1:0]         upd_data
);

    localparam int unsigned IW = $clog2(N);

    state_e        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;

    // Unreset storage: contents survive reset and are rebuilt by seeding.
    logic [W-1:0]  mt [N];

    logic          seed_req;
    logic [W-1:0]  seed_word;
    logic          seed_go;
    logic [IW-1:0] prev_idx;
    logic [W-1:0]  init_word;
    logic [IW-1:0] idx_p1, idx_pm;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [W-1:0]  wr_data;

`ifdef MT_STATE_AUTOSEED_EN
    logic auto_q;

    // High only for the first edge after reset release, injecting the default seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_q <= 1'b1;
        end else begin
            auto_q <= 1'b0;
        end
    end

    assign seed_req  = seed_valid | auto_q;
    assign seed_word = auto_q ? W'(DEFAULT_SEED) : seed;
`else
    assign seed_req  = seed_valid;
    assign seed_word = seed;
`endif

    assign seed_ready = (state_q != StInit);
    assign seed_go    = seed_req && seed_ready;
    assign busy       = (state_q == StInit);
    assign ready      = (state_q == StReady);
    assign idx        = idx_q;

    assign prev_idx = (cnt_q == '0) ? '0 : cnt_q - IW'(1);

    mt_seed_step #(
        .W  (W),
        .IW (IW)
    ) u_seed_step (
        .prev_word (mt[prev_idx]),
        .index     (cnt_q),
        .next_word (init_word)
    );

    // State, init counter and twist index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic; a seed request outranks both init progress and updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (seed_go) begin
            state_d = StInit;
            cnt_d   = IW'(1);
        end else begin
            unique case (state_q)
                StInit: begin
                    cnt_d = cnt_q + IW'(1);
                    if (cnt_q == IW'(N - 1)) begin
                        state_d = StReady;
                        idx_d   = '0;
                    end
                end
                StReady: begin
                    if (upd_valid) begin
                        idx_d = idx_p1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Single array write port; gated by rst_n so nothing is written while held in reset.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (rst_n) begin
            if (seed_go) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = seed_word;
            end else if (state_q == StInit) begin
                wr_en   = 1'b1;
                wr_addr = cnt_q;
                wr_data = init_word;
            end else if ((state_q == StReady) && upd_valid) begin
                wr_en   = 1'b1;
                wr_addr = idx_q;
                wr_data = upd_data;
            end
        end
    end

    // State array storage.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mt[wr_addr] <= wr_data;
        end
    end

    assign idx_p1 = IW'(wrap_add(32'(idx_q), 1, N));
    assign idx_pm = IW'(wrap_add(32'(idx_q), M, N));

    // Combinational taps, forced to zero unless the state is valid.
    always_comb begin
        tap_i  = '0;
        tap_i1 = '0;
        tap_im = '0;
        if (state_q == StReady) begin
            tap_i  = mt[idx_q];
            tap_i1 = mt[idx_p1];
            tap_im = mt[idx_pm];
        end
    end

endmodule
